// File: rtl/tetris_pkg.sv
// Shared playfield constants, line-clear FSM state encoding and the score table.
package tetris_pkg;

  localparam int ROWS   = 20;
  localparam int COLS   = 10;
  localparam int CELL_W = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    FILL = 3'd4,
    DONE = 3'd5
  } state_t;

  function automatic logic [15:0] line_score(input int unsigned n);
    case (n)
      0:       line_score = 16'd0;
      1:       line_score = 16'd100;
      2:       line_score = 16'd300;
      3:       line_score = 16'd500;
      default: line_score = 16'd800;
    endcase
  endfunction

endpackage

// File: rtl/tetris_row_full_detect.sv
// Combinational full-row flag: every cell code of the row is non-zero.
module tetris_row_full_detect
  import tetris_pkg::*;
#(
  parameter int COLS   = tetris_pkg::COLS,
  parameter int CELL_W = tetris_pkg::CELL_W
) (
  input  logic [COLS*CELL_W-1:0] row,
  output logic                   full
);

  always_comb begin
    full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (row[c*CELL_W +: CELL_W] == '0) full = 1'b0;
    end
  end

endmodule

// File: rtl/tetris_row_clear_ctrl.sv
// Bottom-up line-clear sequencer sharing one row port with video (video wins).
// Optional macro ROW_CLEAR_SCORE_EN builds the score table; otherwise score_add is 0.
module tetris_row_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int ROWS   = tetris_pkg::ROWS,
  parameter int COLS   = tetris_pkg::COLS,
  parameter int CELL_W = tetris_pkg::CELL_W
) (
  input  logic                             CLOCK_50,
  input  logic                             RESET_N,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(ROWS+1)-1:0]        lines_cleared,
  output logic [15:0]                      score_add,
  output logic [$clog2(ROWS)-1:0]          mem_addr,
  output logic                             mem_rd,
  output logic                             mem_wr,
  output logic [COLS*CELL_W-1:0]           mem_wdata,
  input  logic [COLS*CELL_W-1:0]           mem_rdata,
  input  logic                             vid_req,
  input  logic [$clog2(ROWS)-1:0]          vid_addr,
  output logic                             vid_gnt
);

  localparam int ROW_W = COLS * CELL_W;
  localparam int AW    = $clog2(ROWS);
  localparam int LW    = $clog2(ROWS + 1);

  state_t           state;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [LW-1:0]    cnt;
  logic [ROW_W-1:0] row_q;
  logic             row_full;
  logic             wr_needed;

  logic [AW-1:0]    ctrl_addr;
  logic             ctrl_rd, ctrl_wr;
  logic [ROW_W-1:0] ctrl_wdata;

  tetris_row_full_detect #(.COLS(COLS), .CELL_W(CELL_W)) u_full (
    .row  (row_q),
    .full (row_full)
  );

  // A surviving row only moves once a full row has been dropped below it.
  assign wr_needed = !row_full && (wr_ptr != rd_ptr);

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      cnt           <= '0;
      lines_cleared <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state  <= RD;
          rd_ptr <= AW'(ROWS - 1);
          wr_ptr <= AW'(ROWS - 1);
          cnt    <= '0;
        end
        RD:   if (!vid_req) state <= CAP;
        CAP:  state <= WR;
        WR: if (!(wr_needed && vid_req)) begin
          if (row_full)            cnt    <= cnt + 1'b1;
          else if (wr_ptr != '0)   wr_ptr <= wr_ptr - 1'b1;
          if (rd_ptr != '0) begin
            rd_ptr <= rd_ptr - 1'b1;
            state  <= RD;
          end else if (row_full || cnt != '0) begin
            state  <= FILL;
          end else begin
            state  <= DONE;
          end
        end
        FILL: if (!vid_req) begin
          if (wr_ptr == '0) state  <= DONE;
          else              wr_ptr <= wr_ptr - 1'b1;
        end
        DONE: begin
          lines_cleared <= cnt;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data returns one cycle after RD issues, i.e. while in CAP.
  always_ff @(posedge CLOCK_50) begin
    if (state == CAP) row_q <= mem_rdata;
  end

`ifdef ROW_CLEAR_SCORE_EN
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N)           score_add <= '0;
    else if (state == DONE) score_add <= line_score(32'(cnt));
  end
`else
  assign score_add = '0;
`endif

  always_comb begin
    ctrl_addr  = '0;
    ctrl_rd    = 1'b0;
    ctrl_wr    = 1'b0;
    ctrl_wdata = '0;
    case (state)
      RD: begin
        ctrl_addr = rd_ptr;
        ctrl_rd   = 1'b1;
      end
      WR: if (wr_needed) begin
        ctrl_addr  = wr_ptr;
        ctrl_wr    = 1'b1;
        ctrl_wdata = row_q;
      end
      FILL: begin
        ctrl_addr = wr_ptr;
        ctrl_wr   = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_addr  = vid_req ? vid_addr : ctrl_addr;
  assign mem_rd    = vid_req | ctrl_rd;
  assign mem_wr    = !vid_req & ctrl_wr;
  assign mem_wdata = vid_req ? '0 : ctrl_wdata;
  assign vid_gnt   = vid_req;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_tetris_row_clear_ctrl.sv
// Directed bench: playfield memory model, compaction/score/latency model and per-cycle port checks.
module tb_tetris_row_clear_ctrl;
  import tetris_pkg::*;

  localparam int ROW_W = COLS * CELL_W;
  localparam int AW    = $clog2(ROWS);
  localparam int LW    = $clog2(ROWS + 1);

  logic             CLOCK_50 = 1'b0;
  logic             RESET_N;
  logic             start;
  logic             busy, done, mem_rd, mem_wr, vid_req, vid_gnt;
  logic [LW-1:0]    lines_cleared;
  logic [15:0]      score_add;
  logic [AW-1:0]    mem_addr, vid_addr;
  logic [ROW_W-1:0] mem_wdata, mem_rdata;

  logic [ROW_W-1:0] mem [ROWS];
  int               wr_total = 0;
  int               checks = 0;
  int               errors = 0;
  bit               model_on = 0;
  bit               exp_busy = 0;
  bit               exp_done = 0;

  tetris_row_clear_ctrl dut (
    .CLOCK_50      (CLOCK_50),
    .RESET_N       (RESET_N),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .score_add     (score_add),
    .mem_addr      (mem_addr),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .vid_req       (vid_req),
    .vid_addr      (vid_addr),
    .vid_gnt       (vid_gnt)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
      wr_total      <= wr_total + 1;
    end
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit row_is_full(input logic [ROW_W-1:0] v);
    for (int c = 0; c < COLS; c++)
      if (v[c*CELL_W +: CELL_W] == '0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_score(input int n);
`ifdef ROW_CLEAR_SCORE_EN
    if (n == 0) return 0;
    if (n == 1) return 100;
    if (n == 2) return 300;
    if (n == 3) return 500;
    return 800;
`else
    return (n < 0) ? 1 : 0;
`endif
  endfunction

  // Port sharing and busy/done timing, checked every cycle.
  always @(negedge CLOCK_50) begin
    if (RESET_N === 1'b1) begin
      chk("vid_gnt", vid_gnt, vid_req);
      if (vid_req) begin
        chk("vid_mux", {mem_addr, mem_rd, mem_wr}, {vid_addr, 1'b1, 1'b0});
      end
      if (model_on) begin
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
      end
    end
  end

  task automatic load_map(input logic [ROWS-1:0] fullm, input int almost);
    logic [ROW_W-1:0] v;
    for (int r = 0; r < ROWS; r++) begin
      v = '0;
      if (fullm[r]) begin
        for (int c = 0; c < COLS; c++) v[c*CELL_W +: CELL_W] = CELL_W'(((r + c) % 7) + 1);
      end else if (r == almost) begin
        for (int c = 0; c < COLS - 1; c++) v[c*CELL_W +: CELL_W] = CELL_W'(3);
      end else begin
        v[CELL_W-1:0] = CELL_W'(r + 1);
      end
      mem[r] <= v;
    end
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic run_scan(input int n_hand, input int stall_hand,
                          input logic [127:0] vmask, input logic [127:0] smask,
                          input int rst_off);
    logic [ROW_W-1:0] exp_map [ROWS];
    int n_model, writes_model, w, done_off, base;
    n_model = 0;
    writes_model = 0;
    w = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (row_is_full(mem[r])) begin
        n_model++;
      end else begin
        exp_map[w] = mem[r];
        if (w != r) writes_model++;
        w--;
      end
    end
    for (int z = w; z >= 0; z--) begin
      exp_map[z] = '0;
      writes_model++;
    end
    chk("model_rows", n_model, n_hand);
    done_off = 3 * ROWS + n_model + stall_hand;

    start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    base = wr_total;
    for (int off = 0; off <= done_off + 2; off++) begin
      vid_req  = vmask[off];
      vid_addr = AW'(off % ROWS);
      start    = (off > 0) && smask[off];
      exp_busy = (off <= done_off);
      exp_done = (off == done_off);
      model_on = 1'b1;
      if (off == rst_off) RESET_N = 1'b0;
      @(posedge CLOCK_50);
      #1;
      if (off == rst_off) begin
        model_on = 1'b0;
        vid_req  = 1'b0;
        start    = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_done", done, 1'b0);
        @(posedge CLOCK_50);
        #1;
        RESET_N = 1'b1;
        return;
      end
    end
    model_on = 1'b0;
    vid_req  = 1'b0;
    start    = 1'b0;
    chk("lines_cleared", lines_cleared, n_model);
    chk("score_add", score_add, model_score(n_model));
    chk("write_count", wr_total - base, writes_model);
    for (int r = 0; r < ROWS; r++) chk($sformatf("row%0d", r), mem[r], exp_map[r]);
  endtask

  initial begin
    logic [127:0] none;
    logic [127:0] vm;
    logic [127:0] sm;
    none = '0;
    RESET_N  = 1'b0;
    start    = 1'b0;
    vid_req  = 1'b0;
    vid_addr = '0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_lines", lines_cleared, 0);
    chk("reset_score", score_add, 0);
    chk("reset_rd", mem_rd, 0);
    chk("reset_wr", mem_wr, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wdata", mem_wdata, 0);
    RESET_N = 1'b1;
    @(posedge CLOCK_50);
    #1;

    // empty map: no writes at all
    load_map('0, -1);
    begin
      int b0;
      b0 = wr_total;
      run_scan(0, 0, none, none, -1);
      chk("empty_no_writes", wr_total - b0, 0);
    end

    // single full bottom row
    load_map(20'h80000, -1);
    run_scan(1, 0, none, none, -1);
    chk("one_row19_cell0", mem[19][CELL_W-1:0], 19);
    chk("one_row1_cell0", mem[1][CELL_W-1:0], 1);
    chk("one_row0_zero", mem[0], 0);
    chk("one_lines", lines_cleared, 1);
`ifdef ROW_CLEAR_SCORE_EN
    chk("one_score", score_add, 100);
`else
    chk("one_score", score_add, 0);
`endif

    // same map with video stalls: 4 in RD, 1 in FILL
    load_map(20'h80000, -1);
    vm = '0;
    vm[0] = 1'b1; vm[1] = 1'b1; vm[2] = 1'b1; vm[6] = 1'b1; vm[64] = 1'b1;
    run_scan(1, 5, vm, none, -1);
    chk("stall_row19_cell0", mem[19][CELL_W-1:0], 19);

    // two full rows, stray start pulses while busy
    load_map(20'h80400, -1);
    sm = '0;
    sm[10] = 1'b1; sm[40] = 1'b1;
    run_scan(2, 0, none, sm, -1);
    chk("two_lines", lines_cleared, 2);

    // four non-adjacent full rows, row 18 missing only its last cell
    load_map(20'hAA000, 18);
    run_scan(4, 0, none, none, -1);
    chk("four_lines", lines_cleared, 4);
    chk("four_row3_zero", mem[3], 0);
    chk("four_row19_keeps18", mem[19], {5'd0, {(COLS-1){5'd3}}});
`ifdef ROW_CLEAR_SCORE_EN
    chk("four_score", score_add, 800);
`else
    chk("four_score", score_add, 0);
`endif

    // reset during FILL, then a fresh full scan
    load_map(20'hAA000, 18);
    run_scan(4, 0, none, none, 61);
    chk("after_rst_lines", lines_cleared, 0);
    run_scan(0, 0, none, none, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
